// File: rtl/noc_tg_pkg.sv
// Shared definitions for the NoC traffic master.
// Holds the FSM state type, payload field offsets and the default destination list.
// No ports.
package noc_tg_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } tg_state_e;

    // Sequence number sits at the bottom of the payload.
    localparam int unsigned SEQ_LSB = 0;

    // Destination id field sits directly above the sequence field.
    function automatic int unsigned dest_lsb(input int unsigned cntw);
        return SEQ_LSB + cntw;
    endfunction

    // Four PEs, entry i is destination id i+1.
    localparam logic [15:0] DEFAULT_DEST_LIST = 16'h4321;

endpackage

// File: rtl/noc_tg_checker.sv
// Response side of the traffic master: classifies returning beats by tdest, keeps
// saturating good/bad counters, folds good payloads into an XOR signature and runs
// the idle timeout counter used while waiting for outstanding responses.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              clear all state at the start of a run
//   en_i               rx beats are consumed only while high (SEND or WAIT)
//   wait_clr_i         clear the timeout counter on entry to WAIT
//   in_wait_i          FSM is in WAIT; timeout counter advances
//   rx_valid_i/data_i/dest_i  response beat from the router
//   recv_count_o, err_count_o, signature_o  registered results
//   recv_next_o        recv count including the beat of the current cycle
//   tmo_expire_o       idle limit reached this cycle
module noc_tg_checker
    import noc_tg_pkg::*;
#(
    parameter int unsigned      DATAW          = 128,
    parameter int unsigned      DESTW          = 4,
    parameter int unsigned      CNTW           = 16,
    parameter logic [DESTW-1:0] OWN_ADDR       = '0,
    parameter int unsigned      TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             wait_clr_i,
    input  logic             in_wait_i,
    input  logic             rx_valid_i,
    input  logic [DATAW-1:0] rx_data_i,
    input  logic [DESTW-1:0] rx_dest_i,
    output logic [CNTW-1:0]  recv_count_o,
    output logic [CNTW-1:0]  err_count_o,
    output logic [DATAW-1:0] signature_o,
    output logic [CNTW-1:0]  recv_next_o,
    output logic             tmo_expire_o
);

    localparam int unsigned     TMOW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMOW-1:0] TmoLast = TMOW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNTW-1:0] CntMax  = '1;

    logic [CNTW-1:0]  recv_d, recv_q;
    logic [CNTW-1:0]  err_d, err_q;
    logic [DATAW-1:0] sig_d, sig_q;
    logic [TMOW-1:0]  tmo_d, tmo_q;
    logic             beat, good;

    assign beat = en_i & rx_valid_i;
    assign good = (rx_dest_i == OWN_ADDR);

    always_comb begin
        recv_d = recv_q;
        err_d  = err_q;
        sig_d  = sig_q;
        tmo_d  = tmo_q;
        if (clr_i) begin
            recv_d = '0;
            err_d  = '0;
            sig_d  = '0;
            tmo_d  = '0;
        end else begin
            if (beat) begin
                if (good) begin
                    if (recv_q != CntMax) recv_d = recv_q + 1'b1;
                    sig_d = sig_q ^ rx_data_i;
                end else if (err_q != CntMax) begin
                    err_d = err_q + 1'b1;
                end
            end
            // Any beat, good or bad, counts as activity and restarts the idle window.
            if (wait_clr_i || beat) begin
                tmo_d = '0;
            end else if (in_wait_i && (tmo_q != TmoLast)) begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            recv_q <= '0;
            err_q  <= '0;
            sig_q  <= '0;
            tmo_q  <= '0;
        end else begin
            recv_q <= recv_d;
            err_q  <= err_d;
            sig_q  <= sig_d;
            tmo_q  <= tmo_d;
        end
    end

    assign recv_count_o = recv_q;
    assign err_count_o  = err_q;
    assign signature_o  = sig_q;
    assign recv_next_o  = recv_d;
    assign tmo_expire_o = in_wait_i & ~beat & (tmo_q == TmoLast);

endmodule

// File: rtl/noc_traffic_master.sv
// Synthetic-benchmark traffic master on NoC local port 0. A start pulse injects
// NUM_PACKETS packets to every destination in DEST_LIST round-robin, then waits for
// the responses (or an idle timeout) and reports done.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           single-cycle run request (IDLE/DONE only)
//   axis_tx_tvalid/tready/tdata/tdest   packets toward router 0
//   axis_rx_tvalid/tdata/tdest      responses from router 0 (always accepted)
//   busy, done, timeout             run status
//   sent_count, recv_count, err_count, signature  run results
module noc_traffic_master
    import noc_tg_pkg::*;
#(
    parameter int unsigned                 DATAW          = 128,
    parameter int unsigned                 DESTW          = 4,
    parameter int unsigned                 NUM_DEST       = 4,
    parameter logic [NUM_DEST*DESTW-1:0]   DEST_LIST      = DEFAULT_DEST_LIST,
    parameter int unsigned                 NUM_PACKETS    = 1,
    parameter logic [DESTW-1:0]            OWN_ADDR       = '0,
    parameter int unsigned                 CNTW           = 16,
    parameter int unsigned                 TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             axis_tx_tvalid,
    input  logic             axis_tx_tready,
    output logic [DATAW-1:0] axis_tx_tdata,
    output logic [DESTW-1:0] axis_tx_tdest,
    input  logic             axis_rx_tvalid,
    input  logic [DATAW-1:0] axis_rx_tdata,
    input  logic [DESTW-1:0] axis_rx_tdest,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNTW-1:0]  sent_count,
    output logic [CNTW-1:0]  recv_count,
    output logic [CNTW-1:0]  err_count,
    output logic [DATAW-1:0] signature
);

    localparam int unsigned     TOTAL    = NUM_DEST * NUM_PACKETS;
    localparam logic [CNTW-1:0] TotalCnt = CNTW'(TOTAL);
    localparam logic [CNTW-1:0] LastCnt  = CNTW'(TOTAL - 1);
    localparam int unsigned     DEST_LSB = dest_lsb(CNTW);
    localparam int unsigned     FILL_LSB = DEST_LSB + DESTW;
    localparam int unsigned     REP      = DATAW / CNTW + 1;
    localparam int unsigned     IDXW     = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam logic [IDXW-1:0] IdxLast  = IDXW'(NUM_DEST - 1);

    tg_state_e        state_q;
    logic [CNTW-1:0]  seq_q, sent_q;
    logic [IDXW-1:0]  idx_q, idx_nxt;
    logic             tvalid_q, timeout_q;
    logic [DATAW-1:0] tdata_q;
    logic [DESTW-1:0] tdest_q;

    logic             hs, last_hs, run_clr, recv_done, tmo_expire;
    logic [CNTW-1:0]  recv_next;

    function automatic logic [DESTW-1:0] dest_of(input logic [IDXW-1:0] idx);
        return DEST_LIST[idx*DESTW +: DESTW];
    endfunction

    // Upper payload bits carry the sequence number repeated from bit 0 upward.
    function automatic logic [DATAW-1:0] build_payload(input logic [CNTW-1:0]  seq,
                                                       input logic [DESTW-1:0] dest);
        logic [REP*CNTW-1:0] rep;
        logic [DATAW-1:0]    p;
        rep = {REP{seq}};
        p   = DATAW'(rep << FILL_LSB);
        p[SEQ_LSB +: CNTW]   = seq;
        p[DEST_LSB +: DESTW] = dest;
        return p;
    endfunction

    // tvalid is held high for the whole of SEND, so tready alone marks a handshake.
    assign hs        = (state_q == StSend) & axis_tx_tready;
    assign last_hs   = hs & (sent_q == LastCnt);
    assign idx_nxt   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    assign run_clr   = start & ((state_q == StIdle) | (state_q == StDone));
    assign recv_done = (recv_next >= TotalCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            seq_q     <= '0;
            sent_q    <= '0;
            idx_q     <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tdest_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StSend;
                        seq_q     <= '0;
                        sent_q    <= '0;
                        idx_q     <= '0;
                        timeout_q <= 1'b0;
                        tvalid_q  <= 1'b1;
                        tdata_q   <= build_payload('0, dest_of('0));
                        tdest_q   <= dest_of('0);
                    end
                end
                StSend: begin
                    if (hs) begin
                        sent_q <= sent_q + 1'b1;
                        seq_q  <= seq_q + 1'b1;
                        idx_q  <= idx_nxt;
                        if (last_hs) begin
                            tvalid_q <= 1'b0;
                            state_q  <= recv_done ? StDone : StWait;
                        end else begin
                            tdata_q <= build_payload(seq_q + 1'b1, dest_of(idx_nxt));
                            tdest_q <= dest_of(idx_nxt);
                        end
                    end
                end
                StWait: begin
                    if (recv_done) begin
                        state_q <= StDone;
                    end else if (tmo_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    noc_tg_checker #(
        .DATAW          (DATAW),
        .DESTW          (DESTW),
        .CNTW           (CNTW),
        .OWN_ADDR       (OWN_ADDR),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_checker (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (run_clr),
        .en_i         (busy),
        .wait_clr_i   (last_hs & ~recv_done),
        .in_wait_i    (state_q == StWait),
        .rx_valid_i   (axis_rx_tvalid),
        .rx_data_i    (axis_rx_tdata),
        .rx_dest_i    (axis_rx_tdest),
        .recv_count_o (recv_count),
        .err_count_o  (err_count),
        .signature_o  (signature),
        .recv_next_o  (recv_next),
        .tmo_expire_o (tmo_expire)
    );

    assign busy           = (state_q == StSend) | (state_q == StWait);
    assign done           = (state_q == StDone);
    assign timeout        = timeout_q;
    assign sent_count     = sent_q;
    assign axis_tx_tvalid = tvalid_q;
    assign axis_tx_tdata  = tdata_q;
    assign axis_tx_tdest  = tdest_q;

endmodule

// File: tb/tb_noc_traffic_master.sv
// Bench for noc_traffic_master: two instances (NUM_PACKETS 1 and 2) driven by a
// per-negedge driver that sets tready, checks every valid tx beat against a packet
// model and plays responses back; the main sequence runs the scenarios.
`timescale 1ns/1ps
module tb_noc_traffic_master;

    localparam int unsigned DATAW = 128;
    localparam int unsigned DESTW = 4;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned NDEST = 4;
    localparam int          TMO   = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start_s  [2];
    logic             tready   [2];
    logic             tvalid   [2];
    logic [DATAW-1:0] tdata    [2];
    logic [DESTW-1:0] tdest    [2];
    logic             rx_valid [2];
    logic [DATAW-1:0] rx_data  [2];
    logic [DESTW-1:0] rx_dest  [2];
    logic             busy     [2];
    logic             done     [2];
    logic             tmo      [2];
    logic [CNTW-1:0]  sent     [2];
    logic [CNTW-1:0]  recv     [2];
    logic [CNTW-1:0]  err      [2];
    logic [DATAW-1:0] sig      [2];

    noc_traffic_master #(.NUM_PACKETS(1), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]),
        .axis_tx_tvalid(tvalid[0]), .axis_tx_tready(tready[0]),
        .axis_tx_tdata(tdata[0]), .axis_tx_tdest(tdest[0]),
        .axis_rx_tvalid(rx_valid[0]), .axis_rx_tdata(rx_data[0]), .axis_rx_tdest(rx_dest[0]),
        .busy(busy[0]), .done(done[0]), .timeout(tmo[0]),
        .sent_count(sent[0]), .recv_count(recv[0]), .err_count(err[0]), .signature(sig[0])
    );

    noc_traffic_master #(.NUM_PACKETS(2), .TIMEOUT_CYCLES(TMO)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]),
        .axis_tx_tvalid(tvalid[1]), .axis_tx_tready(tready[1]),
        .axis_tx_tdata(tdata[1]), .axis_tx_tdest(tdest[1]),
        .axis_rx_tvalid(rx_valid[1]), .axis_rx_tdata(rx_data[1]), .axis_rx_tdest(rx_dest[1]),
        .busy(busy[1]), .done(done[1]), .timeout(tmo[1]),
        .sent_count(sent[1]), .recv_count(recv[1]), .err_count(err[1]), .signature(sig[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int negcnt   = 0;

    // tr_mode: 0 ready, 1 toggle, 2 stall, 3 random. rx_mode: 0 off, 1 echo +3, 2 same cycle.
    int               tr_mode     [2];
    int               rx_mode     [2];
    int               bad_idx     [2];
    int               hs_cnt      [2];
    int               resp_n      [2];
    int               e_recv      [2];
    int               e_err       [2];
    logic [DATAW-1:0] e_sig       [2];
    logic [2:0]       pv          [2];
    logic [DATAW-1:0] pd          [2][3];
    int               last_hs_neg [2];
    int               last_rx_neg [2];
    int               done_neg    [2];
    logic             done_prev   [2];

    function automatic int total(input int u);
        return (u == 0) ? NDEST : 2 * NDEST;
    endfunction

    // Default destination list maps entry i to PE i+1.
    function automatic logic [DESTW-1:0] exp_dest(input int n);
        return DESTW'((n % NDEST) + 1);
    endfunction

    function automatic logic [DATAW-1:0] exp_payload(input int n);
        logic [CNTW-1:0]  seq;
        logic [DATAW-1:0] p;
        seq = CNTW'(n);
        p   = {(DATAW / CNTW){seq}};
        p   = p << (CNTW + DESTW);
        p   = p | (DATAW'(exp_dest(n)) << CNTW) | DATAW'(seq);
        return p;
    endfunction

    task automatic check_val(input string tag, input logic [DATAW-1:0] got,
                             input logic [DATAW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: decides tready for the coming edge, checks the offered packet, replays responses.
    initial begin
        forever begin
            @(negedge clk);
            negcnt++;
            for (int u = 0; u < 2; u++) begin
                logic             hs_now, rv;
                logic [DATAW-1:0] hs_data, rd;
                logic [DESTW-1:0] rdst;
                hs_now  = 1'b0;
                hs_data = '0;
                case (tr_mode[u])
                    0:       tready[u] = 1'b1;
                    1:       tready[u] = ~tready[u];
                    2:       tready[u] = 1'b0;
                    default: tready[u] = 1'($urandom_range(0, 1));
                endcase
                if (tvalid[u] === 1'b1) begin
                    if (hs_cnt[u] < total(u)) begin
                        check_val("tx_tdata", tdata[u], exp_payload(hs_cnt[u]));
                        check_val("tx_tdest", tdest[u], exp_dest(hs_cnt[u]));
                    end else begin
                        check_val("tx_extra_valid", tvalid[u], 1'b0);
                    end
                    if (tready[u]) begin
                        hs_now  = 1'b1;
                        hs_data = exp_payload(hs_cnt[u]);
                        hs_cnt[u]++;
                        last_hs_neg[u] = negcnt;
                    end
                end
                rv = 1'b0;
                rd = '0;
                if (rx_mode[u] == 1) begin
                    rv       = pv[u][2];
                    rd       = pd[u][2];
                    pv[u]    = {pv[u][1:0], hs_now};
                    pd[u][2] = pd[u][1];
                    pd[u][1] = pd[u][0];
                    pd[u][0] = hs_data;
                end else if (rx_mode[u] == 2) begin
                    rv = hs_now;
                    rd = hs_data;
                end
                if (rv) begin
                    rdst = (resp_n[u] == bad_idx[u]) ? 4'h2 : 4'h0;
                    resp_n[u]++;
                    rx_valid[u] = 1'b1;
                    rx_data[u]  = rd;
                    rx_dest[u]  = rdst;
                    if (rdst == 4'h0) begin
                        e_recv[u]++;
                        e_sig[u] = e_sig[u] ^ rd;
                    end else begin
                        e_err[u]++;
                    end
                    last_rx_neg[u] = negcnt;
                end else begin
                    rx_valid[u] = 1'b0;
                end
                if (done[u] === 1'b1 && done_prev[u] !== 1'b1) done_neg[u] = negcnt;
                done_prev[u] = done[u];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic begin_run(input int u);
        hs_cnt[u]   = 0;
        resp_n[u]   = 0;
        e_recv[u]   = 0;
        e_err[u]    = 0;
        e_sig[u]    = '0;
        pv[u]       = '0;
        done_neg[u] = -1;
        start_s[u]  = 1'b1;
        step();
        start_s[u]  = 1'b0;
        check_val("start_tvalid", tvalid[u], 1'b1);
        check_val("start_busy", busy[u], 1'b1);
        check_val("start_done", done[u], 1'b0);
        check_val("start_sent_clr", sent[u], 0);
        check_val("start_recv_clr", recv[u], 0);
        check_val("start_err_clr", err[u], 0);
        check_val("start_sig_clr", sig[u], 0);
        check_val("start_tmo_clr", tmo[u], 1'b0);
    endtask

    task automatic run_to_done(input int u, input int limit);
        int k;
        k = 0;
        while (done[u] !== 1'b1 && k < limit) begin
            step();
            k++;
        end
        check_val("run_done", done[u], 1'b1);
    endtask

    task automatic check_results(input int u);
        check_val("sent_count", sent[u], total(u));
        check_val("tx_handshakes", hs_cnt[u], total(u));
        check_val("recv_count", recv[u], e_recv[u]);
        check_val("err_count", err[u], e_err[u]);
        check_val("signature", sig[u], e_sig[u]);
        check_val("busy_in_done", busy[u], 1'b0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;  tready[u] = 1'b0;  rx_valid[u] = 1'b0;
            rx_data[u] = '0;    rx_dest[u] = '0;
            tr_mode[u] = 0;     rx_mode[u] = 0;    bad_idx[u] = -1;
            hs_cnt[u] = 0;      resp_n[u] = 0;     e_recv[u] = 0;  e_err[u] = 0;
            e_sig[u] = '0;      pv[u] = '0;        done_prev[u] = 1'b0;
            last_hs_neg[u] = 0; last_rx_neg[u] = 0; done_neg[u] = -1;
        end

        // Reset values
        #12;
        for (int u = 0; u < 2; u++) begin
            check_val("rst_tvalid", tvalid[u], 1'b0);
            check_val("rst_tdata", tdata[u], 0);
            check_val("rst_tdest", tdest[u], 0);
            check_val("rst_busy", busy[u], 1'b0);
            check_val("rst_done", done[u], 1'b0);
            check_val("rst_timeout", tmo[u], 1'b0);
            check_val("rst_sent", sent[u], 0);
            check_val("rst_recv", recv[u], 0);
            check_val("rst_err", err[u], 0);
            check_val("rst_sig", sig[u], 0);
        end
        step();
        rst_n = 1'b1;
        step();

        // Basic run, responses echoed three cycles later
        tr_mode[0] = 0; rx_mode[0] = 1; bad_idx[0] = -1;
        begin_run(0);
        run_to_done(0, 200);
        check_results(0);
        check_val("basic_recv_all", recv[0], 4);
        check_val("basic_timeout", tmo[0], 1'b0);

        // A beat arriving in DONE is dropped
        rx_valid[0] = 1'b1;
        rx_data[0]  = {$urandom, $urandom, $urandom, $urandom};
        rx_dest[0]  = 4'h0;
        step();
        step();
        check_val("done_drop_recv", recv[0], e_recv[0]);
        check_val("done_drop_sig", sig[0], e_sig[0]);
        check_val("done_hold", done[0], 1'b1);

        // Backpressure: tready toggles every cycle
        tr_mode[0] = 1;
        begin_run(0);
        run_to_done(0, 200);
        check_results(0);

        // One misaddressed response: run ends by timeout
        tr_mode[0] = 0; bad_idx[0] = $urandom_range(0, 3);
        begin_run(0);
        run_to_done(0, TMO + 200);
        check_results(0);
        check_val("bad_err_one", err[0], 1);
        check_val("bad_recv_three", recv[0], 3);
        check_val("bad_timeout", tmo[0], 1'b1);
        lat = done_neg[0] - last_rx_neg[0];
        check_val("bad_timeout_window", (lat >= TMO && lat <= TMO + 2), 1'b1);

        // Final response in the same cycle as the last handshake: straight to DONE
        bad_idx[0] = -1; rx_mode[0] = 2;
        begin_run(0);
        run_to_done(0, 200);
        check_results(0);
        check_val("simul_timeout", tmo[0], 1'b0);
        check_val("simul_no_wait", done_neg[0] - last_hs_neg[0], 1);

        // Reset while a stalled packet is offered
        tr_mode[0] = 2; rx_mode[0] = 1;
        begin_run(0);
        step();
        step();
        check_val("stall_tvalid", tvalid[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_tvalid", tvalid[0], 1'b0);
        check_val("arst_tdata", tdata[0], 0);
        check_val("arst_tdest", tdest[0], 0);
        check_val("arst_busy", busy[0], 1'b0);
        check_val("arst_done", done[0], 1'b0);
        step();
        rst_n = 1'b1;
        tr_mode[0] = 0;
        step();
        begin_run(0);
        check_val("replay_tdata", tdata[0], exp_payload(0));
        check_val("replay_tdest", tdest[0], 4'd1);
        run_to_done(0, 200);
        check_results(0);

        // Start during WAIT is ignored
        begin_run(0);
        for (int k = 0; k < 50 && hs_cnt[0] < 4; k++) step();
        step();
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        check_val("wait_start_busy", busy[0], 1'b1);
        run_to_done(0, 200);
        check_results(0);

        // NUM_PACKETS=2 instance, random ready, run twice
        tr_mode[1] = 3; rx_mode[1] = 1; bad_idx[1] = -1;
        for (int r = 0; r < 2; r++) begin
            begin_run(1);
            run_to_done(1, 600);
            check_results(1);
            check_val("np2_recv_all", recv[1], 8);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_traffic_master.md
Name: noc_traffic_master

Overview:
Traffic-generating master that sits on local port 0 of the NoC, directly upstream of router 0's AXIS input and downstream of its AXIS output.
- On a start pulse it injects NUM_PACKETS packets to each PE destination, round-robin.
- It accepts every returning response, since the router output tready is tied high.
- It counts and validates responses and folds them into an XOR signature.
- It reports done or timeout status for the synthetic benchmark.

Parameters:
- DATAW, 128, AXIS tdata width.
- DESTW, 4, AXIS tdest width.
- NUM_DEST, 4, number of PE destinations.
- DEST_LIST, 16'h4321, packed list of NUM_DEST destination ids; entry i is DEST_LIST[i*DESTW +: DESTW].
- NUM_PACKETS, 1, packets sent per destination per run.
- OWN_ADDR, 4'h0, tdest that valid responses must carry.
- CNTW, 16, width of the counters and the sequence number.
- TIMEOUT_CYCLES, 1024, idle cycles allowed in WAIT before aborting.

Ports:
- clk  in  1  user clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- axis_tx_tvalid  out  1  packet valid toward the router.
- axis_tx_tready  in  1  router ready.
- axis_tx_tdata  out  DATAW  packet payload.
- axis_tx_tdest  out  DESTW  packet destination.
- axis_rx_tvalid  in  1  response valid from the router.
- axis_rx_tdata  in  DATAW  response payload.
- axis_rx_tdest  in  DESTW  response destination.
- busy  out  1  high in SEND and WAIT.
- done  out  1  high in DONE.
- timeout  out  1  sticky flag: the run ended by timeout.
- sent_count  out  CNTW  packets accepted by the router.
- recv_count  out  CNTW  valid responses received.
- err_count  out  CNTW  responses with a wrong tdest.
- signature  out  DATAW  XOR of all valid response tdata.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All flops reset asynchronously on rst_n=0.
- Reset values: every output is 0; state=IDLE; seq=0; dest index=0.
- TOTAL = NUM_DEST*NUM_PACKETS; it must be below 2^CNTW.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE or DONE, start=1:
  - clear all counters, signature, timeout, seq and dest index;
  - next state is SEND;
  - tvalid rises on the next cycle (1-cycle start-to-valid latency).
- start is ignored in SEND and WAIT.
- SEND, packet format:
  - tdata[CNTW-1:0] = seq;
  - tdata[CNTW +: DESTW] = current destination;
  - remaining upper bits = seq replicated, truncated to fit;
  - tdest = DEST_LIST[idx].
- SEND, handshake rules:
  - tdata and tdest stay stable while tvalid=1 and tready=0;
  - tvalid never drops without a handshake.
- SEND, on each handshake (tvalid & tready):
  - sent_count++ and seq++;
  - idx = (idx+1) mod NUM_DEST.
- SEND, last packet: the handshake with sent_count==TOTAL-1 deasserts tvalid on the next cycle and moves to WAIT. If recv_count already reaches TOTAL on that same cycle, the FSM goes directly to DONE.
- RX acceptance:
  - in SEND and WAIT, every cycle with axis_rx_tvalid=1 is consumed; there is no backpressure;
  - tdest==OWN_ADDR: recv_count++ and signature ^= tdata;
  - otherwise err_count++ and signature is unchanged;
  - rx beats in IDLE or DONE are dropped and no counter changes.
- recv_count saturates at all-ones and err_count saturates likewise.
- WAIT exit on completion: when recv_count reaches TOTAL (including the increment of the current cycle), the FSM moves to DONE the next cycle.
- WAIT timeout counter:
  - reset to 0 on entry to WAIT and on every rx beat;
  - incremented otherwise;
  - on reaching TIMEOUT_CYCLES-1, timeout=1 and the FSM moves to DONE.
- DONE: done=1 and busy=0. Counters, signature and timeout hold until the next start.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no partial packet is left with tvalid asserted.

Decomposition:
- Shared package noc_tg_pkg holds:
  - the state enum {IDLE, SEND, WAIT, DONE};
  - the payload field offsets (SEQ_LSB, DEST_LSB);
  - the default DEST_LIST constant.
- One sub-module, noc_tg_checker, covers the rx side: tdest compare, recv/err counters with saturation, signature register, and timeout counter. Its inputs are an enable (SEND|WAIT) and a WAIT-entry clear.
- The top level holds the FSM and the tx datapath.

Test Plan:
- Basic run: reset, start, tready=1, and each tx packet echoed back 3 cycles later with tdest=0. Required: tx tdest sequence 1,2,3,4; sent_count=4; recv_count=4; err_count=0; signature = XOR of the four payloads; done=1; timeout=0.
- Backpressure: tready toggles 0/1 every cycle. Required: tdata/tdest stay stable while stalled; seq values 0..3 each sent exactly once; sent_count=4.
- Bad responses: return one response with tdest=4'h2. Required: err_count=1, recv_count=3, then after TIMEOUT_CYCLES idle cycles timeout=1 and done=1.
- Simultaneous events: the final rx beat arrives in the same cycle as the last tx handshake. Required: direct SEND→DONE, with no WAIT cycle.
- Reset mid-operation: assert rst_n=0 during SEND with tvalid=1. Required: outputs go to 0 asynchronously. A new start after reset replays from seq=0 to dest 1.
- Start while busy and repeat run: a start pulse during WAIT is ignored. A second start after DONE clears the counters, and NUM_PACKETS=2 gives sent_count=8.
